// File: rtl/draw_seq_pkg.sv
// Shared types and the region table for the draw sequencer.
// Rectangle bounds are inclusive. A region with lower > upper on either axis is empty and gets skipped.
package draw_seq_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int MAX_REGIONS = 16;

  typedef struct packed {
    logic [7:0] lx;
    logic [7:0] ux;
    logic [6:0] ly;
    logic [6:0] uy;
  } region_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_ARM,
    S_WAIT,
    S_FINISH
  } state_t;

  localparam region_t REGION_FULL   = '{lx: 8'd0,  ux: 8'(SCREEN_W - 1), ly: 7'd0,  uy: 7'(SCREEN_H - 1)};
  localparam region_t REGION_TOP    = '{lx: 8'd40, ux: 8'd119, ly: 7'd30, uy: 7'd49};
  localparam region_t REGION_BOTTOM = '{lx: 8'd40, ux: 8'd119, ly: 7'd70, uy: 7'd89};
  localparam region_t REGION_EMPTY  = '{lx: 8'd10, ux: 8'd5,   ly: 7'd0,  uy: 7'd0};

  // Entries above index 3 are empty so that larger NUM_REGIONS settings simply skip them.
  localparam region_t [MAX_REGIONS-1:0] REGION_TABLE = {
    {(MAX_REGIONS - 4){REGION_EMPTY}},
    REGION_EMPTY, REGION_BOTTOM, REGION_TOP, REGION_FULL
  };

  function automatic logic region_empty(input region_t r);
    return (r.lx > r.ux) || (r.ly > r.uy);
  endfunction

endpackage

// File: rtl/draw_region_rom.sv
// Combinational lookup from region index to rectangle bounds.
module draw_region_rom
  import draw_seq_pkg::*;
(
  input  logic [3:0] region_idx,
  output region_t    region
);

  assign region = REGION_TABLE[region_idx];

endmodule

// File: rtl/draw_sequencer.sv
// Walks the region table and hands each rectangle to the downstream drawer with a start/done handshake.
// Define DRAW_SEQ_TIMEOUT_EN to build the per-region watchdog. Without it, timeout_err is tied low.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int NUM_REGIONS    = 4,
  parameter int TIMEOUT_CYCLES = 20000
)
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       trigger,
  input  logic       abort,
  input  logic       drawer_done,
  output logic       drawer_start,
  output logic [7:0] lowerXBound,
  output logic [7:0] upperXBound,
  output logic [6:0] lowerYBound,
  output logic [6:0] upperYBound,
  output logic [3:0] region_idx,
  output logic       busy,
  output logic       seq_done,
  output logic       timeout_err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGIONS - 1);

  state_t  state, next_state, decision;
  region_t region;
  logic    abort_pending, abort_now, accept, wd_fire;

  draw_region_rom u_rom (
    .region_idx (region_idx),
    .region     (region)
  );

  assign abort_now = abort | abort_pending;
  assign accept    = (state == S_IDLE) && trigger && !abort;
  assign decision  = abort_now ? S_IDLE : ((region_idx == LAST_IDX) ? S_FINISH : S_LOAD);

`ifdef DRAW_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_count;

  assign wd_fire = (state == S_WAIT) && !drawer_done && (wd_count == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wd_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != S_WAIT)
        wd_count <= '0;
      else
        wd_count <= wd_count + 1'b1;
      if (accept)
        timeout_err <= 1'b0;
      else if (wd_fire)
        timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_fire            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = S_LOAD;
      S_LOAD: begin
        if (abort_now)                 next_state = S_IDLE;
        else if (region_empty(region)) next_state = decision;
        else                           next_state = S_START;
      end
      S_START:  next_state = S_ARM;
      // The drawer's done flag is still high from the previous rectangle here.
      S_ARM:    next_state = S_WAIT;
      S_WAIT: begin
        if (drawer_done)  next_state = decision;
        else if (wd_fire) next_state = S_IDLE;
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // All outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      drawer_start  <= 1'b0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      region_idx    <= '0;
      abort_pending <= 1'b0;
      lowerXBound   <= '0;
      upperXBound   <= '0;
      lowerYBound   <= '0;
      upperYBound   <= '0;
    end else begin
      drawer_start <= (next_state == S_START);
      busy         <= (next_state != S_IDLE);
      seq_done     <= (next_state == S_FINISH);
      if (accept)
        region_idx <= '0;
      else if ((state == S_LOAD || state == S_WAIT) && next_state == S_LOAD)
        region_idx <= region_idx + 4'd1;
      if (state == S_LOAD) begin
        lowerXBound <= region.lx;
        upperXBound <= region.ux;
        lowerYBound <= region.ly;
        upperYBound <= region.uy;
      end
      if (next_state == S_IDLE)
        abort_pending <= 1'b0;
      else if (abort && state != S_IDLE)
        abort_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: drawer model, event-schedule reference, vector table, random episodes.
// The watchdog scenario runs on a second instance only when DRAW_SEQ_TIMEOUT_EN is defined.
module tb_draw_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, trigger, abort, drawer_done;
  logic       drawer_start, busy, seq_done, timeout_err;
  logic [7:0] lowerXBound, upperXBound;
  logic [6:0] lowerYBound, upperYBound;
  logic [3:0] region_idx;

  draw_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .trigger      (trigger),
    .abort        (abort),
    .drawer_done  (drawer_done),
    .drawer_start (drawer_start),
    .lowerXBound  (lowerXBound),
    .upperXBound  (upperXBound),
    .lowerYBound  (lowerYBound),
    .upperYBound  (upperYBound),
    .region_idx   (region_idx),
    .busy         (busy),
    .seq_done     (seq_done),
    .timeout_err  (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Bench's own copy of the region table, taken from the written requirements.
  int ref_lx [4] = '{0, 40, 40, 10};
  int ref_ux [4] = '{159, 119, 119, 5};
  int ref_ly [4] = '{0, 30, 70, 0};
  int ref_uy [4] = '{119, 49, 89, 0};

  function automatic int area(input int i);
    return (ref_ux[i] - ref_lx[i] + 1) * (ref_uy[i] - ref_ly[i] + 1);
  endfunction

  function automatic logic is_empty(input int i);
    return (ref_lx[i] > ref_ux[i]) || (ref_ly[i] > ref_uy[i]);
  endfunction

  // Drawer: done falls after the stale cycle and rises area cycles after the start pulse.
  int draw_cnt = 0;
  always @(posedge clock) begin : drawer_model
    int a;
    if (!reset_n) begin
      drawer_done <= 1'b0;
      draw_cnt    <= 0;
    end else if (drawer_start) begin
      a = (int'(upperXBound) - int'(lowerXBound) + 1) * (int'(upperYBound) - int'(lowerYBound) + 1);
      if (a <= 1) drawer_done <= 1'b1;
      else        draw_cnt    <= a - 1;
    end else if (draw_cnt != 0) begin
      draw_cnt    <= draw_cnt - 1;
      drawer_done <= (draw_cnt == 1);
    end
  end

  typedef struct {
    int slot;
    int idx;
    int lx, ux, ly, uy;
  } start_rec_t;

  start_rec_t starts[$];
  int         done_slots[$];

  always @(negedge clock) begin
    if (drawer_start === 1'b1)
      starts.push_back('{cyc, int'(region_idx), int'(lowerXBound), int'(upperXBound),
                         int'(lowerYBound), int'(upperYBound)});
    if (seq_done === 1'b1)
      done_slots.push_back(cyc);
  end

  task automatic applyStimulus(input logic t, input logic a, input logic r);
    trigger = t;
    abort   = a;
    reset_n = r;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkAll(input string tag, input int eb, input int es, input int ed, input int ei,
                          input int lx, input int ux, input int ly, input int uy);
    checkOutput({tag, " busy"}, int'(busy), eb);
    checkOutput({tag, " drawer_start"}, int'(drawer_start), es);
    checkOutput({tag, " seq_done"}, int'(seq_done), ed);
    checkOutput({tag, " region_idx"}, int'(region_idx), ei);
    checkOutput({tag, " lowerX"}, int'(lowerXBound), lx);
    checkOutput({tag, " upperX"}, int'(upperXBound), ux);
    checkOutput({tag, " lowerY"}, int'(lowerYBound), ly);
    checkOutput({tag, " upperY"}, int'(upperYBound), uy);
    checkOutput({tag, " timeout_err"}, int'(timeout_err), 0);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: busy=%b after %0d cycles", busy, budget);
    end
  endtask

  task automatic waitStarts(input int count, input int budget);
    int n = 0;
    while (starts.size() < count && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (starts.size() < count) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitStarts: got %0d starts, wanted %0d", starts.size(), count);
    end
  endtask

  // Reference schedule: a sequence loaded at slot t starts each non-empty region one slot after its
  // load and loads the next one area+2 slots after that load; an empty region costs one slot.
  int exp_slots[$];
  int exp_idx[$];

  task automatic buildSchedule(input int t, output int fin);
    int load = t;
    fin = -1;
    exp_slots.delete();
    exp_idx.delete();
    for (int i = 0; i < 4; i++) begin
      int nxt;
      if (is_empty(i)) begin
        nxt = load + 1;
      end else begin
        exp_slots.push_back(load + 1);
        exp_idx.push_back(i);
        nxt = load + area(i) + 2;
      end
      if (i == 3) fin = nxt;
      else        load = nxt;
    end
  endtask

  typedef struct {
    logic t, a, r;
    int   busy, start, idx, lx, ux, ly, uy;
  } vec_t;

  task automatic runTable();
    vec_t vecs[14];
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 159, 0, 119};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 159, 0, 119};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 159, 0, 119};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 159, 0, 119};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 159, 0, 119};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 159, 0, 119};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].t, vecs[i].a, vecs[i].r);
      checkAll($sformatf("vec%0d", i), vecs[i].busy, vecs[i].start, 0, vecs[i].idx,
               vecs[i].lx, vecs[i].ux, vecs[i].ly, vecs[i].uy);
    end
  endtask

  // Random episodes end in a reset well before region 0 can finish, so the expected outputs
  // depend only on when abort lands relative to the accepted trigger.
  task automatic runRandom();
    for (int ep = 0; ep < 10; ep++) begin
      int a, r, sp, pre;
      a   = int'($urandom_range(0, 7));
      r   = int'($urandom_range(4, 30));
      sp  = (a >= 2) ? int'($urandom_range(2, r - 1)) : -1;
      pre = int'($urandom_range(0, 3));
      for (int k = 0; k < pre; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      for (int n = 0; n <= r; n++) begin
        int eb, es, ebd;
        applyStimulus((n == 0) || (n == sp), (n == a) && (a < 7), (n != r));
        if (n == r) begin
          checkAll($sformatf("rnd%0d reset", ep), 0, 0, 0, 0, 0, 0, 0, 0);
        end else begin
          eb  = (a == 0) ? 0 : ((a == 1) ? int'(n == 0) : 1);
          es  = int'(a >= 2 && n == 1);
          ebd = int'(a != 0 && n >= 1);
          checkOutput($sformatf("rnd%0d busy", ep), int'(busy), eb);
          checkOutput($sformatf("rnd%0d start", ep), int'(drawer_start), es);
          checkOutput($sformatf("rnd%0d seq_done", ep), int'(seq_done), 0);
          checkOutput($sformatf("rnd%0d idx", ep), int'(region_idx), 0);
          checkOutput($sformatf("rnd%0d upperX", ep), int'(upperXBound), ebd ? 159 : 0);
          checkOutput($sformatf("rnd%0d upperY", ep), int'(upperYBound), ebd ? 119 : 0);
        end
      end
    end
  endtask

`ifdef DRAW_SEQ_TIMEOUT_EN
  logic       trigger2 = 1'b0;
  logic       abort2   = 1'b0;
  logic       done2    = 1'b0;
  logic       start2, busy2, seq_done2, terr2;
  logic [7:0] lx2, ux2;
  logic [6:0] ly2, uy2;
  logic [3:0] idx2;
  int         seq_done2_count = 0;

  draw_sequencer #(.TIMEOUT_CYCLES(50)) dut_wd (
    .clock        (clock),
    .reset_n      (reset_n),
    .trigger      (trigger2),
    .abort        (abort2),
    .drawer_done  (done2),
    .drawer_start (start2),
    .lowerXBound  (lx2),
    .upperXBound  (ux2),
    .lowerYBound  (ly2),
    .upperYBound  (uy2),
    .region_idx   (idx2),
    .busy         (busy2),
    .seq_done     (seq_done2),
    .timeout_err  (terr2)
  );

  always @(negedge clock) if (seq_done2 === 1'b1) seq_done2_count++;

  task automatic runTimeout();
    int t2, n;
    trigger2 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    trigger2 = 1'b0;
    t2 = cyc;
    checkOutput("wd busy after trigger", int'(busy2), 1);
    n = 0;
    while (busy2 === 1'b1 && n < 100) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("wd idle slot", cyc - t2, 53);
    checkOutput("wd timeout_err set", int'(terr2), 1);
    checkOutput("wd busy low", int'(busy2), 0);
    checkOutput("wd no seq_done", seq_done2_count, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wd timeout_err sticky", int'(terr2), 1);
    trigger2 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    trigger2 = 1'b0;
    checkOutput("wd timeout_err cleared", int'(terr2), 0);
    checkOutput("wd busy on retrigger", int'(busy2), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    int t, fin, idle_slot;
    trigger = 1'b0;
    abort   = 1'b0;
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Full sequence with a second trigger that must be ignored.
    starts.delete();
    done_slots.delete();
    applyStimulus(1'b1, 1'b0, 1'b1);
    t = cyc;
    buildSchedule(t, fin);
    checkOutput("seq LOAD busy", int'(busy), 1);
    checkOutput("seq LOAD no start", int'(drawer_start), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("seq first start", 1, 1, 0, 0, 0, 159, 0, 119);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitIdle(30000);
    checkOutput("seq start count", starts.size(), 3);
    for (int i = 0; i < 3 && i < starts.size(); i++) begin
      checkOutput($sformatf("seq start%0d slot", i), starts[i].slot - t, exp_slots[i] - t);
      checkOutput($sformatf("seq start%0d idx", i), starts[i].idx, exp_idx[i]);
      checkOutput($sformatf("seq start%0d lx", i), starts[i].lx, ref_lx[exp_idx[i]]);
      checkOutput($sformatf("seq start%0d ux", i), starts[i].ux, ref_ux[exp_idx[i]]);
      checkOutput($sformatf("seq start%0d ly", i), starts[i].ly, ref_ly[exp_idx[i]]);
      checkOutput($sformatf("seq start%0d uy", i), starts[i].uy, ref_uy[exp_idx[i]]);
    end
    checkOutput("seq done count", done_slots.size(), 1);
    if (done_slots.size() > 0)
      checkOutput("seq done slot", done_slots[0] - t, fin - t);
    checkOutput("seq idle slot", cyc - t, fin + 1 - t);
    checkAll("seq retained", 0, 0, 0, 3, 10, 5, 0, 0);

    // Abort while region 1 is drawing: region 1 completes, nothing after it.
    starts.delete();
    done_slots.delete();
    applyStimulus(1'b1, 1'b0, 1'b1);
    t = cyc;
    buildSchedule(t, fin);
    waitStarts(2, 25000);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitIdle(5000);
    idle_slot = exp_slots[1] + area(1) + 1;
    checkOutput("abort start count", starts.size(), 2);
    checkOutput("abort done count", done_slots.size(), 0);
    checkOutput("abort idle slot", cyc - t, idle_slot - t);
    checkAll("abort retained", 0, 0, 0, 1, 40, 119, 30, 49);

    runTable();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runRandom();
`ifdef DRAW_SEQ_TIMEOUT_EN
    runTimeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
